alu_seq_param: RTL and testbench
================================

# alu_seq_param

Parametrised, registered successor to the team's 16-bit ALU. Width is set by `WIDTH`, and half-width operation on the low `WIDTH/2` bits is kept. The block adds a start/busy/done handshake and iterative multiply/divide. It sits between the register file/address register outputs (A, B) and the write-back mux, and drives the 4-bit flag register read by the control unit.

## Interface
- `WIDTH`, 16: operand/result width; even, ≥ 8.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `A`  in  WIDTH  operand A; sampled only on an accepted Start.
- `B`  in  WIDTH  operand B; sampled only on an accepted Start.
- `FunSel`  in  6  operation select; sampled on an accepted Start.
- `WF`  in  1  write-flags enable; sampled on an accepted Start.
- `Start`  in  1  request; accepted at a rising edge only when Busy=0.
- `Busy`  out  1  multi-cycle operation in progress.
- `Done`  out  1  one-cycle pulse: ALUOut and flags updated.
- `ALUOut`  out  WIDTH  registered result.
- `FlagsOut`  out  4  {Z, C, N, O} = [3:0].

## Operation
- **FunSel[5]=0, single-cycle operations.**
  - FunSel[4] selects the width. 1 = full WIDTH. 0 = low H=WIDTH/2 bits, with ALUOut[WIDTH-1:H] forced to 0.
  - FunSel[3:0]: 0 A, 1 B, 2 ~A, 3 ~B, 4 A+B, 5 A+B+C, 6 A−B (A+~B+1), 7 AND, 8 OR, 9 XOR, A NAND, B LSL, C LSR, D ASR, E ROL through C, F ROR through C.
- **FunSel[5]=1, multi-cycle operations.** Always full WIDTH; FunSel[4:2] are ignored. FunSel[1:0]: 0 MUL low half, 1 MUL high half (unsigned 2·WIDTH product), 2 DIVU quotient, 3 DIVU remainder.
- **Flags.** Written only when the latched WF=1, at the same edge as ALUOut.
  - Z: the selected-width result equals 0.
  - N: MSB of the selected width (bit H−1 in half mode).
  - C, add/sub: carry out of the selected width. For subtract, C=1 means no borrow.
  - C, LSL/ROL: shifted-out MSB. C, LSR/ROR: shifted-out LSB.
  - C, MUL: 1 if the high half of the product is non-zero.
  - C is unchanged by all other single-cycle operations (pass-through, NOT, logic, ASR). DIVU writes C=0.
  - O, add: operands have equal sign and the result sign differs.
  - O, sub: operands have different sign and the result sign differs from A.
  - O, MUL: 0. O, DIVU: 1 on divide by zero.
  - O is unchanged by all other single-cycle operations.
- Carry-in for operations 5, E and F is the registered FlagsOut[2].
- **Divide by zero.** Quotient is all ones; remainder is A.
- **States.**
  - IDLE: on Start with FunSel[5]=0 → stay in IDLE. On Start with FunSel[5]=1 → RUN; latch operands and load the cycle counter with WIDTH.
  - RUN: one shift-add or shift-subtract step per cycle while the counter decrements. At count 0, write the result and flags, pulse Done, and return to IDLE.
- Start is ignored while Busy=1, and no state is altered by it.

## Timing
- Reset values: ALUOut=0, FlagsOut=0, Busy=0, Done=0, state IDLE, counter 0.
- Reset acts immediately, including mid-RUN; the partial result is discarded.
- Single-cycle operation, Start accepted at edge k:
  - ALUOut and flags are updated at edge k.
  - Done=1 for the cycle after edge k.
  - Busy is never asserted.
- Multi-cycle operation, Start accepted at edge k:
  - Busy=1 from edge k until edge k+WIDTH.
  - ALUOut and flags are updated at edge k+WIDTH, when Busy falls.
  - Done=1 in the following cycle.
  - Latency is WIDTH+1 edges to the Done cycle.
- Back-to-back: Start is accepted in any Done cycle, including same-cycle Start and Done.
- ALUOut holds its value between operations.

## Configuration
- `ALU_MULDIV_EN` defined: multiply/divide datapath and the RUN state are present, as specified above.
- `ALU_MULDIV_EN` undefined: any FunSel[5]=1 request completes as a single-cycle operation. ALUOut=0, FlagsOut is not written regardless of WF, and Busy stays 0.

## Test plan
All scenarios use WIDTH=16.
- **Reset:** assert Reset mid-cycle → ALUOut=0x0000, FlagsOut=0000, Busy=0, Done=0, asynchronously.
- **Full add:** FunSel=010100, A=0x7FFF, B=0x0001, WF=1 → ALUOut=0x8000, FlagsOut={Z0,C0,N1,O1}; Done one cycle after the edge.
- **Half sub:** FunSel=000110, A=0x1234, B=0x0034 → ALUOut=0x0000, FlagsOut={Z1,C1,N0,O0}. Then FunSel=001110 (ROL) with A=0x0080 → ALUOut=0x0001, C=1.
- **Multiply:** FunSel=100000, A=0x1234, B=0x0100 → Busy for 16 cycles, ALUOut=0x3400, C=1. FunSel=100001 with the same operands → ALUOut=0x0012. A Start pulsed while Busy is ignored.
- **Divide:** A=1000, B=7 → quotient 0x008E, remainder 0x0006. B=0 → quotient 0xFFFF, remainder = A, O=1.
- **Reset mid-multiply:** assert Reset at RUN cycle 5 → Busy=0 at once, no Done pulse. A fresh Start after release completes normally.

Source files
------------

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered WIDTH-bit ALU with a Start/Busy/Done handshake.
// Single-cycle ops finish at the accepting edge. With ALU_MULDIV_EN defined,
// FunSel[5]=1 runs an iterative shift-add multiply or restoring divide.
// Without ALU_MULDIV_EN, those requests return 0 and leave the flags alone.
module alu_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       FunSel,
    input  logic             WF,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic             accept, md_req, last;
    logic [WIDTH-1:0] md_res;
    logic [3:0]       md_flags;
    logic             md_fwr;

    assign accept = Start && (state == IDLE);
    assign Busy   = (state == RUN);

    // sign bit of the selected width
    function automatic logic top_bit(input logic [WIDTH-1:0] x, input logic hf);
        return hf ? x[H-1] : x[WIDTH-1];
    endfunction

    // single-cycle datapath; half mode works on zero-extended low halves
    logic             half, cin, ci, is_sub;
    logic [WIDTH-1:0] mask, msk_top, a, b, bx, sc_r;
    logic [WIDTH:0]   sum;
    logic             sc_z, sc_c, sc_n, sc_o, sc_fwr;

    always_comb begin
        half    = ~FunSel[4];
        mask    = half ? {{(WIDTH-H){1'b0}}, {H{1'b1}}} : {WIDTH{1'b1}};
        msk_top = half ? {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}}
                       : {1'b1, {(WIDTH-1){1'b0}}};
        a       = A & mask;
        b       = B & mask;
        cin     = FlagsOut[2];
        is_sub  = (FunSel[3:0] == 4'h6);
        bx      = is_sub ? (~b & mask) : b;
        ci      = is_sub | ((FunSel[3:0] == 4'h5) & cin);
        sum     = '0;
        sc_r    = '0;
        sc_c    = FlagsOut[2];
        sc_o    = FlagsOut[0];
        case (FunSel[3:0])
            4'h0: sc_r = a;
            4'h1: sc_r = b;
            4'h2: sc_r = ~a;
            4'h3: sc_r = ~b;
            4'h4, 4'h5, 4'h6: begin
                sum  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
                sc_r = sum[WIDTH-1:0];
                sc_c = half ? sum[H] : sum[WIDTH];
                if (is_sub)
                    sc_o = (top_bit(a, half) != top_bit(b, half)) &&
                           (top_bit(sum[WIDTH-1:0] & mask, half) != top_bit(a, half));
                else
                    sc_o = (top_bit(a, half) == top_bit(b, half)) &&
                           (top_bit(sum[WIDTH-1:0] & mask, half) != top_bit(a, half));
            end
            4'h7: sc_r = a & b;
            4'h8: sc_r = a | b;
            4'h9: sc_r = a ^ b;
            4'hA: sc_r = ~(a & b);
            4'hB: begin sc_r = a << 1; sc_c = top_bit(a, half); end
            4'hC: begin sc_r = a >> 1; sc_c = a[0]; end
            4'hD: sc_r = (a >> 1) | (top_bit(a, half) ? msk_top : '0);
            4'hE: begin sc_r = (a << 1) | {{(WIDTH-1){1'b0}}, cin}; sc_c = top_bit(a, half); end
            4'hF: begin sc_r = (a >> 1) | (cin ? msk_top : '0); sc_c = a[0]; end
        endcase
        // multi-cycle select reaching here only happens with mul/div compiled out
        sc_r   = FunSel[5] ? '0 : (sc_r & mask);
        sc_z   = (sc_r == '0);
        sc_n   = top_bit(sc_r, half);
        sc_fwr = WF & ~FunSel[5];
    end

`ifdef ALU_MULDIV_EN
    // hi/lo hold {partial product, multiplier} or {remainder, quotient}
    logic [1:0]       op_q;
    logic             wf_q;
    logic [WIDTH-1:0] hi, lo, dv, hi_nx, lo_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   msum, shl, diff;

    assign md_req = FunSel[5];
    assign last   = Busy && (cnt == CW'(1));

    // one shift-add (MUL) or restoring shift-subtract (DIVU) step
    always_comb begin
        msum = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
        shl  = {hi, lo[WIDTH-1]};
        diff = shl - {1'b0, dv};
        if (!op_q[1]) begin
            hi_nx = msum[WIDTH:1];
            lo_nx = {msum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_nx = diff[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nx = shl[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], 1'b0};
        end
        md_res   = op_q[0] ? hi_nx : lo_nx;
        md_flags = {md_res == '0, ~op_q[1] & (|hi_nx), md_res[WIDTH-1], op_q[1] & (dv == '0)};
        md_fwr   = wf_q;
    end

    // operand latch and iteration registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_q <= '0; wf_q <= 1'b0; hi <= '0; lo <= '0; dv <= '0; cnt <= '0;
        end else if (accept && md_req) begin
            op_q <= FunSel[1:0]; wf_q <= WF; hi <= '0; lo <= A; dv <= B;
            cnt  <= CW'(WIDTH);
        end else if (Busy) begin
            hi <= hi_nx; lo <= lo_nx; cnt <= cnt - CW'(1);
        end
    end
`else
    assign md_req   = 1'b0;
    assign last     = 1'b0;
    assign md_res   = '0;
    assign md_flags = '0;
    assign md_fwr   = 1'b0;
`endif

    // state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state: RUN only for an accepted multi-cycle request
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && md_req) state_nx = RUN;
            RUN:  if (last)             state_nx = IDLE;
        endcase
    end

    // result, flags and Done pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ALUOut   <= '0;
            FlagsOut <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept && !md_req) begin
                ALUOut <= sc_r;
                Done   <= 1'b1;
                if (sc_fwr) FlagsOut <= {sc_z, sc_c, sc_n, sc_o};
            end else if (last) begin
                ALUOut <= md_res;
                Done   <= 1'b1;
                if (md_fwr) FlagsOut <= md_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: vector table plus scoreboard for alu_seq_param (WIDTH=16).
// Builds with or without ALU_MULDIV_EN; mul/div expectations follow the build.
module tb_alu_seq_param;
    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset, WF, Start, Busy, Done;
    logic [W-1:0] A, B, ALUOut;
    logic [5:0]   FunSel;
    logic [3:0]   FlagsOut;

    always #5 Clock = ~Clock;

    alu_seq_param #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
        .Start(Start), .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
    );

    typedef struct {
        logic [5:0]   fs;
        logic [W-1:0] a, b;
        logic         wf;
        logic [W-1:0] out;
        logic [3:0]   fl;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic [3:0]   fl;
        int           t0;
        int           lat;
        string        name;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] fl_model = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // fl is the full expected flag state after the op; mul/div requests
    // collapse to "result 0, flags untouched" when the datapath is absent
    function automatic vec_t mk(input logic [5:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic wf, input logic [W-1:0] out, input logic [3:0] fl);
        vec_t v;
        v.fs = fs; v.a = a; v.b = b; v.wf = wf; v.out = out; v.fl = fl; v.lat = 1;
`ifdef ALU_MULDIV_EN
        if (fs[5]) v.lat = W + 1;
`else
        if (fs[5]) begin v.out = '0; v.fl = fl_model; end
`endif
        fl_model = v.fl;
        return v;
    endfunction

    // scoreboard: every Done pops one expectation
    always @(negedge Clock) begin
        if (!Reset && Done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL stray_done: Done=1 with nothing outstanding, cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_out"},   ALUOut,              mon_e.out);
                chk({mon_e.name, "_flags"}, 16'(FlagsOut),       16'(mon_e.fl));
                chk({mon_e.name, "_lat"},   16'(cyc - mon_e.t0), 16'(mon_e.lat));
            end
        end
    end

    task automatic issue(input vec_t v, input string nm);
        exp_t e;
        @(negedge Clock);
        FunSel = v.fs; A = v.a; B = v.b; WF = v.wf; Start = 1'b1;
        e.out = v.out; e.fl = v.fl; e.t0 = cyc; e.lat = v.lat; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        @(negedge Clock);
        Start = 1'b0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge Clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        Reset = 1'b0; Start = 1'b0; A = '0; B = '0; FunSel = '0; WF = 1'b0;
        #1 Reset = 1'b1;
        #1;
        chk("rst_out",   ALUOut,        16'h0000);
        chk("rst_flags", 16'(FlagsOut), 16'h0000);
        chk("rst_busy",  16'(Busy),     16'h0000);
        chk("rst_done",  16'(Done),     16'h0000);
        @(negedge Clock);
        #2 Reset = 1'b0;

        // {Z,C,N,O}
        vecs.push_back(mk(6'b010100, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0011)); // full add ovf
        vecs.push_back(mk(6'b000110, 16'h1234, 16'h0034, 1'b1, 16'h0000, 4'b1100)); // half sub
        vecs.push_back(mk(6'b001110, 16'h0080, 16'h0000, 1'b1, 16'h0001, 4'b0100)); // half ROL, C in
        vecs.push_back(mk(6'b010101, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1100)); // ADC carry
        vecs.push_back(mk(6'b010110, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 4'b0010)); // sub borrow
        vecs.push_back(mk(6'b010110, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0101)); // sub ovf
        vecs.push_back(mk(6'b010111, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 4'b0111)); // AND
        vecs.push_back(mk(6'b011001, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 4'b0111)); // XOR, WF=0
        vecs.push_back(mk(6'b001000, 16'h12F0, 16'h340F, 1'b1, 16'h00FF, 4'b0111)); // half OR
        vecs.push_back(mk(6'b011010, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 4'b1101)); // NAND
        vecs.push_back(mk(6'b011011, 16'h8001, 16'h0000, 1'b1, 16'h0002, 4'b0101)); // LSL
        vecs.push_back(mk(6'b001100, 16'hFF02, 16'h0000, 1'b1, 16'h0001, 4'b0001)); // half LSR
        vecs.push_back(mk(6'b001101, 16'h0081, 16'h0000, 1'b1, 16'h00C0, 4'b0011)); // half ASR
        vecs.push_back(mk(6'b011111, 16'h0001, 16'h0000, 1'b1, 16'h0000, 4'b1101)); // ROR cin=0
        vecs.push_back(mk(6'b011111, 16'h0002, 16'h0000, 1'b1, 16'h8001, 4'b0011)); // ROR cin=1
        vecs.push_back(mk(6'b000011, 16'h0000, 16'h00FF, 1'b1, 16'h0000, 4'b1001)); // half NOT B
        vecs.push_back(mk(6'b000000, 16'hABCD, 16'h0000, 1'b1, 16'h00CD, 4'b0011)); // half pass A
        vecs.push_back(mk(6'b010001, 16'h1111, 16'h0000, 1'b1, 16'h0000, 4'b1001)); // pass B
        vecs.push_back(mk(6'b000100, 16'h007F, 16'h0001, 1'b1, 16'h0080, 4'b0011)); // half add ovf
        vecs.push_back(mk(6'b000100, 16'h12FF, 16'h3401, 1'b1, 16'h0000, 4'b1100)); // half add carry
        vecs.push_back(mk(6'b000101, 16'h0010, 16'h0020, 1'b1, 16'h0031, 4'b0000)); // half ADC
        vecs.push_back(mk(6'b100000, 16'h1234, 16'h0100, 1'b1, 16'h3400, 4'b0100)); // MUL lo
        vecs.push_back(mk(6'b100001, 16'h1234, 16'h0100, 1'b1, 16'h0012, 4'b0100)); // MUL hi
        vecs.push_back(mk(6'b100010, 16'd1000, 16'd7,    1'b1, 16'h008E, 4'b0000)); // DIVU q
        vecs.push_back(mk(6'b100011, 16'd1000, 16'd7,    1'b1, 16'h0006, 4'b0000)); // DIVU r
        vecs.push_back(mk(6'b100010, 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 4'b0011)); // div0 q
        vecs.push_back(mk(6'b100011, 16'h1234, 16'h0000, 1'b1, 16'h1234, 4'b0001)); // div0 r
        vecs.push_back(mk(6'b100000, 16'h0000, 16'h0005, 1'b1, 16'h0000, 4'b1000)); // MUL zero
        vecs.push_back(mk(6'b111101, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 4'b0110)); // FunSel[4:2] ignored

        foreach (vecs[i]) begin
            issue(vecs[i], $sformatf("v%0d", i));
            drain($sformatf("v%0d", i));
        end

        // back-to-back: second Start lands in the first op's Done cycle
        issue(mk(6'b010100, 16'h0001, 16'h0002, 1'b1, 16'h0003, 4'b0000), "b2b_a");
        issue(mk(6'b010100, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0011), "b2b_b");
        @(negedge Clock);
        Start = 1'b0;
        // asynchronous reset in the middle of a Done cycle
        #2 Reset = 1'b1;
        #1;
        chk("areset_out",   ALUOut,        16'h0000);
        chk("areset_flags", 16'(FlagsOut), 16'h0000);
        chk("areset_done",  16'(Done),     16'h0000);
        chk("areset_busy",  16'(Busy),     16'h0000);
        sb.delete();
        fl_model = '0;
        @(negedge Clock);
        #2 Reset = 1'b0;

`ifdef ALU_MULDIV_EN
        // Busy width, and a Start mid-run that must be ignored
        issue(mk(6'b100000, 16'h1234, 16'h0100, 1'b1, 16'h3400, 4'b0100), "mul_busy");
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (i == 3) begin FunSel = 6'b010000; A = 16'hFFFF; WF = 1'b1; Start = 1'b1; end
            else Start = 1'b0;
            if (Busy) bc++;
        end
        chk("busy_cycles", 16'(bc), 16'd16);
        chk("mul_busy_pending", 16'(sb.size()), 16'd0);
        sb.delete();

        // reset at RUN cycle 5: Busy drops at once, no Done follows
        issue(mk(6'b100001, 16'h1234, 16'h0100, 1'b1, 16'h0012, 4'b0100), "mul_rst");
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        chk("run5_busy", 16'(Busy), 16'h0001);
        #2 Reset = 1'b1;
        #1;
        chk("midrun_busy", 16'(Busy),  16'h0000);
        chk("midrun_done", 16'(Done),  16'h0000);
        chk("midrun_out",  ALUOut,     16'h0000);
        sb.delete();
        fl_model = '0;
        @(negedge Clock);
        #2 Reset = 1'b0;
        repeat (20) @(negedge Clock);
        issue(mk(6'b100010, 16'd1000, 16'd7, 1'b1, 16'h008E, 4'b0000), "post_rst_div");
        drain("post_rst_div");
`else
        // mul/div compiled out: single-cycle, no Busy
        issue(mk(6'b100000, 16'h1234, 16'h0100, 1'b1, 16'h3400, 4'b0100), "md_off");
        @(negedge Clock);
        Start = 1'b0;
        chk("md_off_busy", 16'(Busy), 16'h0000);
        drain("md_off");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
